// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-allocate cache with true-LRU ages and a word-serial miss fill.
// Latency: hit completes in the request cycle; a miss costs memory latency + WORDS + 2 cycles.
// Backpressure: stall holds the requester until the miss completes; memory words are accepted whenever valid in FILL.
module assoc_cache #(
  parameter int ADDR_WIDTH = 16,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int WORDS      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic [15:0]           data_in,
  output logic [15:0]           data_out,
  output logic                  stall,
  output logic                  miss_detected,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           mem_data,
  input  logic                  mem_data_valid
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_WIDTH - SET_W - OFF_W - 1;

  // Reset ages: way w starts with age w, giving a valid permutation.
  function automatic logic [WAYS*WAY_W-1:0] age_init();
    age_init = '0;
    for (int w = 0; w < WAYS; w++) begin
      age_init[w*WAY_W +: WAY_W] = WAY_W'(w);
    end
  endfunction

  localparam logic [WAYS*WAY_W-1:0] AGE_INIT = age_init();

  typedef enum logic [1:0] {IDLE, FILL, UPDATE} state_t;

  state_t state, state_nxt;

  logic [OFF_W-1:0] off;
  logic [SET_W-1:0] set_idx;
  logic [TAG_W-1:0] tag_f;
  logic             unused_addr_lsb;

  assign off             = addr[OFF_W:1];
  assign set_idx         = addr[OFF_W+SET_W:OFF_W+1];
  assign tag_f           = addr[ADDR_WIDTH-1:OFF_W+SET_W+1];
  assign unused_addr_lsb = addr[0];

  logic [WAYS-1:0][SETS-1:0]             valid;
  logic [SETS-1:0][WAYS-1:0][WAY_W-1:0]  age;
  logic [TAG_W-1:0]                      tag_arr  [WAYS][SETS];
  logic [15:0]                           data_mem [WAYS][SETS][WORDS];

  logic [WAY_W-1:0] victim, victim_sel, hit_way, lru_way;
  logic [OFF_W:0]   issue_cnt;
  logic [OFF_W-1:0] recv_cnt;
  logic             req, hit, lru_upd, issue_more;
  logic [WAYS-1:0][WAY_W-1:0] age_row, age_row_nxt;

  assign req        = rd_req | wr_req;
  assign issue_more = (issue_cnt < (OFF_W+1)'(WORDS));
  assign lru_upd    = ((state == IDLE) && req && hit) || (state == UPDATE);
  assign lru_way    = (state == UPDATE) ? victim : hit_way;

  // Tag compare across all ways of the addressed set; at most one way matches.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w][set_idx] && (tag_arr[w][set_idx] == tag_f)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    victim_sel = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age[set_idx][w] == WAY_W'(WAYS-1)) victim_sel = WAY_W'(w);
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid[w][set_idx]) victim_sel = WAY_W'(w);
    end
  end

  // Next ages for the addressed set: accessed way becomes youngest, younger ways age by one.
  always_comb begin
    age_row     = age[set_idx];
    age_row_nxt = age_row;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == lru_way) begin
        age_row_nxt[w] = '0;
      end else if (age_row[w] < age_row[lru_way]) begin
        age_row_nxt[w] = age_row[w] + 1'b1;
      end
    end
  end

  // Miss FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and outputs; reset forces every output low without waiting for a clock.
  always_comb begin
    state_nxt     = state;
    stall         = 1'b0;
    miss_detected = 1'b0;
    data_out      = '0;
    mem_rd_req    = 1'b0;
    mem_addr      = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (rd_req) data_out = data_mem[hit_way][set_idx][off];
          end else begin
            stall         = 1'b1;
            miss_detected = 1'b1;
            state_nxt     = FILL;
          end
        end
      end
      FILL: begin
        stall         = 1'b1;
        miss_detected = 1'b1;
        if (issue_more) begin
          mem_rd_req = 1'b1;
          mem_addr   = {tag_f, set_idx, issue_cnt[OFF_W-1:0], 1'b0};
        end
        if (mem_data_valid && (recv_cnt == OFF_W'(WORDS-1))) state_nxt = UPDATE;
      end
      UPDATE: begin
        stall         = 1'b1;
        miss_detected = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst) begin
      stall         = 1'b0;
      miss_detected = 1'b0;
      data_out      = '0;
      mem_rd_req    = 1'b0;
      mem_addr      = '0;
    end
  end

  // Control state: valid bits, ages, victim and the fill counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid     <= '0;
      age       <= {SETS{AGE_INIT}};
      victim    <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      if (lru_upd) age[set_idx] <= age_row_nxt;
      case (state)
        IDLE: begin
          if (req && !hit) begin
            victim                      <= victim_sel;
            valid[victim_sel][set_idx]  <= 1'b0;
            issue_cnt                   <= '0;
            recv_cnt                    <= '0;
          end
        end
        FILL: begin
          if (issue_more)     issue_cnt <= issue_cnt + 1'b1;
          if (mem_data_valid) recv_cnt  <= recv_cnt + 1'b1;
        end
        UPDATE: valid[victim][set_idx] <= 1'b1;
        default: ;
      endcase
    end
  end

  // Data and tag storage carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && wr_req && hit)    data_mem[hit_way][set_idx][off]     <= data_in;
    if ((state == FILL) && mem_data_valid)   data_mem[victim][set_idx][recv_cnt] <= mem_data;
    if (state == UPDATE)                     tag_arr[victim][set_idx]            <= tag_f;
  end

endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: scoreboard bench with a recency-list cache model and a latency-programmable memory.
// Requests are issued one at a time and held while stall is high.
// A monitor pops expected responses (data, stall cycles) and the memory checks every word address.
module tb_assoc_cache;

  localparam int AW = 16, WAYS = 2, SETS = 64, WORDS = 8;
  localparam int TAG_W = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr, data_in, data_out, mem_addr, mem_data;
  logic        rd_req, wr_req, stall, miss_detected, mem_rd_req, mem_data_valid;

  assoc_cache #(.ADDR_WIDTH(AW), .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
    .data_in(data_in), .data_out(data_out), .stall(stall), .miss_detected(miss_detected),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int lat = 1, gap_at = -1, gap_left = 0, gap_pos = 0, word_idx = 0;
  bit mon_en = 1'b0, want_gap = 1'b0;

  typedef struct {bit is_rd; logic [15:0] a; logic [15:0] data; int pen;} exp_t;
  typedef struct {logic [15:0] a; int due;} pend_t;
  exp_t        exp_q[$];
  logic [15:0] exp_maddr[$];
  pend_t       pend[$];

  // Reference cache: per set, resident blocks ordered most- to least-recently used.
  int          mcnt [SETS];
  logic [TAG_W-1:0] mtag [SETS][WAYS];
  logic [15:0] mdat [SETS][WAYS][WORDS];

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return (a >> 1) + 16'h0FE0;
  endfunction

  function automatic void model_access(input bit wr, input logic [15:0] a, input logic [15:0] d,
                                       output bit miss, output logic [15:0] rdat);
    int s, o, pos, last;
    logic [TAG_W-1:0] kt;
    logic [15:0] kd [WORDS];
    o = int'(a[3:1]);
    s = int'(a[9:4]);
    pos = -1;
    for (int i = 0; i < mcnt[s]; i++) if (mtag[s][i] == a[15:10]) pos = i;
    miss = (pos < 0);
    if (miss) begin
      kt = a[15:10];
      for (int w = 0; w < WORDS; w++) kd[w] = mem_val({a[15:4], 4'h0} + 16'(2*w));
      if (mcnt[s] < WAYS) mcnt[s]++;
      last = mcnt[s] - 1;
    end else begin
      kt = mtag[s][pos];
      for (int w = 0; w < WORDS; w++) kd[w] = mdat[s][pos][w];
      last = pos;
    end
    for (int i = last; i > 0; i--) begin
      mtag[s][i] = mtag[s][i-1];
      for (int w = 0; w < WORDS; w++) mdat[s][i][w] = mdat[s][i-1][w];
    end
    mtag[s][0] = kt;
    for (int w = 0; w < WORDS; w++) mdat[s][0][w] = kd[w];
    if (wr) mdat[s][0][o] = d;
    rdat = mdat[s][0][o];
  endfunction

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that retires the request.
  task automatic do_req(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    bit miss;
    logic [15:0] rdat;
    exp_t ex;
    int n;
    model_access(wr, a, d, miss, rdat);
    gap_left = (miss && want_gap) ? 2 : 0;
    gap_at   = gap_pos;
    ex.is_rd = rd && !wr;
    ex.a     = a;
    ex.data  = rdat;
    ex.pen   = miss ? lat + WORDS + 2 + gap_left : 0;
    if (miss) for (int w = 0; w < WORDS; w++) exp_maddr.push_back({a[15:4], 4'h0} + 16'(2*w));
    exp_q.push_back(ex);
    addr = a; rd_req = rd; wr_req = wr; data_in = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 200);
    if (stall) begin
      tests++; fails++;
      $display("FAIL req_timeout addr=%h still stalled after %0d cycles", a, n);
      finish_tb();
    end
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  // Response monitor: counts stall/miss cycles of the current request and checks at completion.
  int   st_cnt = 0, md_cnt = 0;
  exp_t me;
  always @(negedge clk) begin
    if (mon_en && rst && (rd_req || wr_req)) begin
      if (stall) st_cnt++;
      if (miss_detected) md_cnt++;
      if (!stall) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_completion addr=%h", addr);
        end else begin
          me = exp_q.pop_front();
          tests++;
          if (st_cnt != me.pen) begin
            fails++;
            $display("FAIL stall_cycles addr=%h got %0d expected %0d", me.a, st_cnt, me.pen);
          end
          tests++;
          if (md_cnt != me.pen) begin
            fails++;
            $display("FAIL miss_cycles addr=%h got %0d expected %0d", me.a, md_cnt, me.pen);
          end
          if (me.is_rd) begin
            tests++;
            if (data_out !== me.data) begin
              fails++;
              $display("FAIL rd_data addr=%h got %h expected %h", me.a, data_out, me.data);
            end
          end
        end
        st_cnt = 0;
        md_cnt = 0;
      end
    end
  end

  // Memory request side: every issued word address is checked against the expected fill sequence.
  logic [15:0] ema;
  pend_t       np;
  always @(negedge clk) begin
    if (rst && mem_rd_req) begin
      tests++;
      if (exp_maddr.size() == 0) begin
        fails++;
        $display("FAIL mem_addr unexpected request got %h", mem_addr);
      end else begin
        ema = exp_maddr.pop_front();
        if (mem_addr !== ema) begin
          fails++;
          $display("FAIL mem_addr got %h expected %h", mem_addr, ema);
        end
      end
      np.a   = mem_addr;
      np.due = cyc + lat;
      pend.push_back(np);
    end
  end

  // Memory return side: in-order words after the latency, with an optional two-cycle hole.
  initial begin
    mem_data = '0;
    mem_data_valid = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      mem_data_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        if (word_idx == gap_at && gap_left > 0) begin
          gap_left--;
        end else begin
          mem_data       = mem_val(pend[0].a);
          mem_data_valid = 1'b1;
          void'(pend.pop_front());
          word_idx = (word_idx + 1) % WORDS;
        end
      end
    end
  end

  initial begin
    #500000;
    tests++; fails++;
    $display("FAIL watchdog expired");
    finish_tb();
  end

  initial begin
    addr = '0; rd_req = 1'b0; wr_req = 1'b0; data_in = '0;
    for (int s = 0; s < SETS; s++) mcnt[s] = 0;
    rd_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_miss", {31'd0, miss_detected}, 32'd0);
    chk("reset_data_out", {16'd0, data_out}, 32'd0);
    chk("reset_mem_rd_req", {31'd0, mem_rd_req}, 32'd0);
    chk("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
    rd_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_req_stall", {31'd0, stall}, 32'd0);
    mon_en = 1'b1;

    // Cold miss, hit in same block, write hit then read back.
    lat = 1;
    do_req(1'b1, 1'b0, 16'h0040, 16'h0);
    do_req(1'b1, 1'b0, 16'h0046, 16'h0);
    do_req(1'b0, 1'b1, 16'h0042, 16'hBEEF);
    do_req(1'b1, 1'b0, 16'h0042, 16'h0);

    // LRU in set 5: A, B, touch A, C evicts B, A hits, B misses.
    lat = 2;
    do_req(1'b1, 1'b0, 16'h0450, 16'h0);
    do_req(1'b1, 1'b0, 16'h0852, 16'h0);
    do_req(1'b1, 1'b0, 16'h0454, 16'h0);
    do_req(1'b1, 1'b0, 16'h0C56, 16'h0);
    do_req(1'b1, 1'b0, 16'h0458, 16'h0);
    do_req(1'b1, 1'b0, 16'h085A, 16'h0);

    // Latency 3, then a fill with a two-cycle hole before word 4; read every word back.
    lat = 3;
    do_req(1'b1, 1'b0, 16'h1270, 16'h0);
    want_gap = 1'b1; gap_pos = 4;
    do_req(1'b1, 1'b0, 16'h1680, 16'h0);
    want_gap = 1'b0;
    for (int w = 0; w < WORDS; w++) do_req(1'b1, 1'b0, 16'h1680 + 16'(2*w), 16'h0);

    // Reset in the middle of a fill, with words still arriving afterwards.
    mon_en = 1'b0;
    lat = 1;
    for (int w = 0; w < WORDS; w++) exp_maddr.push_back(16'h2A60 + 16'(2*w));
    addr = 16'h2A60; rd_req = 1'b1; wr_req = 1'b0;
    begin
      int n = 0;
      while (word_idx != 5 && n < 100) begin
        @(posedge clk); #2;
        n++;
      end
    end
    if (word_idx != 5) begin
      tests++; fails++;
      $display("FAIL t6_fill_progress got %0d words expected 5", word_idx);
      finish_tb();
    end
    @(posedge clk); #2;
    chk("t6_stall_in_fill", {31'd0, stall}, 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_rst_stall", {31'd0, stall}, 32'd0);
    chk("t6_rst_miss", {31'd0, miss_detected}, 32'd0);
    chk("t6_rst_mem_rd_req", {31'd0, mem_rd_req}, 32'd0);
    chk("t6_rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("t6_rst_data_out", {16'd0, data_out}, 32'd0);
    rd_req = 1'b0;
    #2 rst = 1'b1;
    begin
      int n = 0;
      while (pend.size() > 0 && n < 20) begin
        @(posedge clk);
        n++;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("t6_idle_stall", {31'd0, stall}, 32'd0);
    chk("t6_idle_mem_rd_req", {31'd0, mem_rd_req}, 32'd0);
    exp_maddr.delete();
    pend.delete();
    word_idx = 0;
    for (int s = 0; s < SETS; s++) mcnt[s] = 0;
    mon_en = 1'b1;
    do_req(1'b1, 1'b0, 16'h2A60, 16'h0);
    do_req(1'b1, 1'b0, 16'h2A6A, 16'h0);
    do_req(1'b1, 1'b0, 16'h0046, 16'h0);

    // Randomized traffic over a few conflicting sets.
    for (int k = 0; k < 150; k++) begin
      logic [15:0] a;
      int r;
      a = {6'($urandom_range(0, 3)), 6'($urandom_range(4, 6)), 3'($urandom_range(0, 7)), 1'b0};
      lat = $urandom_range(1, 4);
      want_gap = ($urandom_range(0, 3) == 0);
      gap_pos = $urandom_range(0, 7);
      r = $urandom_range(0, 19);
      if (r < 12)      do_req(1'b1, 1'b0, a, 16'h0);
      else if (r < 19) do_req(1'b0, 1'b1, a, 16'($urandom));
      else             do_req(1'b1, 1'b1, a, 16'($urandom));
      want_gap = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("end_exp_q_empty", exp_q.size(), 32'd0);
    chk("end_mem_addr_q_empty", exp_maddr.size(), 32'd0);
    finish_tb();
  end

endmodule
